// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default constants for the round-robin arbiter
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 4;
  localparam int ARB_ID_W     = $clog2(ARB_N);

endpackage

// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - combinational rotating-priority search
//
// Ports:
//   request   in  N      : request levels, bit i = requester i
//   ptr       in  ID_W   : last-granted index; search starts at ptr+1
//   win_valid out 1      : some request bit is set
//   win_id    out ID_W   : first requesting index in order ptr+1 .. ptr (mod N)
module rr_prio_sel #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    request,
  input  logic [ID_W-1:0] ptr,
  output logic            win_valid,
  output logic [ID_W-1:0] win_id
);

  // Walk the candidates from lowest to highest priority so the last hit
  // wins; offset N lands on ptr itself, making the current owner the final
  // candidate.
  always_comb begin
    int unsigned idx;
    win_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (request[idx[ID_W-1:0]]) begin
        win_valid = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant
//
// Build option: RR_ARB_HOLD_LIMIT_EN enables the MAX_HOLD burst limit.
//
// Ports:
//   clk         in  1     : clock, rising edge
//   rst         in  1     : synchronous active-high reset
//   request     in  N     : per-requester request level
//   grant       out N     : registered grant, one-hot or zero
//   grant_valid out 1     : registered, equals |grant
//   grant_id    out ID_W  : registered owner index, 0 when idle
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int ID_W = $clog2(N);

  if (N < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
  end

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            valid_q, valid_d;

  logic            win_valid;
  logic [ID_W-1:0] win_id;
  logic [N-1:0]    win_onehot;

  rr_prio_sel #(
    .N    (N),
    .ID_W (ID_W)
  ) u_prio_sel (
    .request   (request),
    .ptr       (ptr_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_id;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              others_pending;

  assign others_pending = |(request & ~grant_q);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = BUSY;
          ptr_d   = win_id;
          grant_d = win_onehot;
          id_d    = win_id;
          valid_d = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d  = HOLD_W'(1);
`endif
        end
      end
      BUSY: begin
        if (!request[id_q]) begin
          // Owner released: the search can only hit another requester here,
          // so hand off in the same edge when one is waiting.
          if (win_valid) begin
            ptr_d   = win_id;
            grant_d = win_onehot;
            id_d    = win_id;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_d  = HOLD_W'(1);
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_d  = '0;
`endif
          end
        end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          // Burst exhausted with someone waiting: the search from ptr+1
          // reaches every other requester before the owner at ptr.
          if (hold_q == HOLD_MAX && others_pending) begin
            ptr_d   = win_id;
            grant_d = win_onehot;
            id_d    = win_id;
            hold_d  = HOLD_W'(1);
          end else if (hold_q != HOLD_MAX) begin
            hold_d  = hold_q + HOLD_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(N - 1);
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int n_checks;
  int n_fail;

  rr_arbiter #(
    .N        (4),
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two edges with the given request, then releases it.
  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic do_reset(input logic [3:0] req);
    @(negedge clk);
    rst     = 1'b1;
    request = req;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst     = 1'b1;
    request = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: grant=%b id=%0d valid=%b, need 0000/0/0",
                 c, grant, grant_id, grant_valid);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b id=%0d valid=%b, need 0001/0/1",
               grant, grant_id, grant_valid);
    end
  endtask

`ifdef RR_ARB_HOLD_LIMIT_EN
  task automatic test_burst_limit();
    logic [3:0] exp_g;
    logic [1:0] exp_id;
    do_reset(4'b1111);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      exp_id = 2'((c / 4) % 4);
      exp_g  = 4'b0001 << exp_id;
      n_checks++;
      if (grant !== exp_g || grant_id !== exp_id || grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_limit cycle %0d: grant=%b id=%0d, need %b id=%0d",
                 c, grant, grant_id, exp_g, exp_id);
      end
    end
  endtask
`else
  task automatic test_no_limit();
    do_reset(4'b1111);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0001 || grant_id !== 2'd0) begin
        n_fail++;
        $display("FAIL no_limit_hold cycle %0d: grant=%b id=%0d, need 0001 id=0",
                 c, grant, grant_id);
      end
    end
    request = 4'b1110;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL no_limit_release: grant=%b id=%0d, need 0010 id=1", grant, grant_id);
    end
  endtask
`endif

  task automatic test_handoff();
    do_reset(4'b0001);
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL handoff_owner0: grant=%b, need 0001", grant);
    end
    request = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL handoff_keep: grant=%b, need 0001", grant);
    end
    request = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff_switch: grant=%b id=%0d valid=%b, need 0100/2/1",
               grant, grant_id, grant_valid);
    end
    request = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_idle: grant=%b id=%0d valid=%b, need 0000/0/0",
               grant, grant_id, grant_valid);
    end
  endtask

  task automatic test_release_order();
    // Owner 1 releases with 0,2,3 waiting: search from 2 picks 2, not 0.
    do_reset(4'b0010);
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL order_owner1: grant=%b, need 0010", grant);
    end
    request = 4'b1101;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL order_next: grant=%b id=%0d, need 0100 id=2", grant, grant_id);
    end
    // Owner 2 releases with 0,1 waiting: wrap past 3 to 0.
    request = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL order_wrap: grant=%b id=%0d, need 0001 id=0", grant, grant_id);
    end
  endtask

  task automatic test_single();
    do_reset(4'b1000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b1000 || grant_id !== 2'd3 || grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single cycle %0d: grant=%b id=%0d valid=%b, need 1000/3/1",
                 c, grant, grant_id, grant_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(4'b0100);
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_reset_owner2: grant=%b, need 0100", grant);
    end
    request = 4'b1111;
    rst     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: grant=%b id=%0d valid=%b, need 0000/0/0",
               grant, grant_id, grant_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_ptr: grant=%b id=%0d, need 0001 id=0", grant, grant_id);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    request  = 4'b0000;
    test_reset();
`ifdef RR_ARB_HOLD_LIMIT_EN
    test_burst_limit();
`else
    test_no_limit();
`endif
    test_handoff();
    test_release_order();
    test_single();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
